fpu_result_collector: RTL and testbench
=======================================

# fpu_result_collector

Output-side counterpart of the FPU input-enable FSM. It sits at the tail of the add/sub pipeline and tracks every operation the input side issues. It captures each result and exception flags into a small buffer, presents them to the consumer over a valid/ready handshake, and applies credit-based backpressure (`stall_o`) to the input side, because the fixed-latency pipeline itself cannot stall.

## Interface
- `W`, 32: result width.
- `DEPTH`, 2: result buffer entries; power of 2, range 2..8.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `issue_i` input 1: one-cycle pulse per operand set accepted into pipeline stage 0.
- `pipe_valid_i` input 1: result token leaving the last pipeline stage.
- `pipe_result_i` input W: result data, qualified by `pipe_valid_i`.
- `pipe_flags_i` input 2: [1] overflow, [0] underflow; qualified by `pipe_valid_i`.
- `ready_out_i` input 1: consumer ready.
- `valid_out_o` output 1: buffer head valid.
- `result_o` output W: buffer head result.
- `flags_o` output 2: buffer head flags.
- `stall_o` output 1: input side must not issue.
- `busy_o` output 1: at least one operation in flight or buffered.
- `done_o` output 1: last outstanding result handed off.
- `err_o` output 1: sticky protocol error.

## Operation
- Counters:
  - `occ`: buffered entries, 0..DEPTH.
  - `inflight`: issued but not yet returned, 0..DEPTH.
  - Both are $clog2(DEPTH+1) bits, registered.
- Credit rule: `stall_o = (occ + inflight >= DEPTH) | (state == ERROR)`, computed from registered values.
- Accepted issue: `issue_i & ~stall_o` increments `inflight`.
- Rejected issue: `issue_i & stall_o` moves the FSM to ERROR; `inflight` is not incremented.
- Push: `pipe_valid_i & (inflight != 0) & (state != ERROR)` writes {flags, result} at `wr_ptr` and decrements `inflight`.
- Spurious token: `pipe_valid_i & (inflight == 0)` moves the FSM to ERROR; the data is discarded.
- Simultaneous accepted issue and push: `inflight` is unchanged.
- Pop: `valid_out_o & ready_out_i` advances `rd_ptr`.
- Simultaneous push and pop: `occ` is unchanged. A push can never find the buffer full, because the credit rule guarantees it.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `valid_out_o = (occ != 0)`. `result_o` and `flags_o` are read from the head entry. There is no bypass: an empty buffer never forwards `pipe_result_i`.
- `busy_o = (occ != 0) | (inflight != 0)`.
- `done_o = pop & (occ == 1) & (inflight == 0) & ~push`. It is combinational, one cycle wide.
- FSM states:
  - IDLE: `busy_o` = 0. An accepted issue goes to ACTIVE.
  - ACTIVE: returns to IDLE on the cycle `done_o` fires with no accepted issue in that same cycle.
  - ERROR: reached from any state on a protocol violation. `err_o` = 1, `stall_o` = 1, pushes are ignored, the buffer still drains. Exit only via `rst`.
- `err_o = (state == ERROR)`.

## Timing
- Reset values:
  - `valid_out_o` 0, `result_o` 0, `flags_o` 0.
  - `stall_o` 0, `busy_o` 0, `done_o` 0, `err_o` 0.
  - `occ` 0, `inflight` 0, pointers 0, state IDLE.
  - Buffer contents are cleared to 0.
- Reset mid-operation discards all in-flight and buffered results. Tokens arriving after reset count as spurious.
- `pipe_valid_i` high at cycle N → `valid_out_o` high at N+1 (1-cycle capture latency).
- Pop at cycle N → next entry presented at N+1. Back-to-back pops sustain 1 result/cycle.
- Accepted issue at N → `stall_o` reflects the new credit count at N+1.
- Pop at N → `stall_o` may deassert at N+1.
- Protocol violation at N → `err_o` = 1 from N+1.
- While `valid_out_o` is high and `ready_out_i` is low, `result_o` and `flags_o` hold stable.

## Structure
- `fpu_pkg` holds:
  - the FSM state enum: IDLE = 2'd0, ACTIVE = 2'd1, ERROR = 2'd2;
  - the flag bit indices: `FLAG_OVF` = 1, `FLAG_UDF` = 0;
  - default `W`.
- Sub-module `result_fifo`: register-array FIFO, width W+2, depth DEPTH, with push/pop/`occ` outputs.
- Credit counter, error detection and FSM live in the top level.

## Test plan
- Single op, DEPTH=2:
  - Stimulus: `issue_i` at c0; `pipe_valid_i` at c6 with result 0x3F800000, flags 2'b00; `ready_out_i` = 1.
  - Response: `valid_out_o` = 1 with result 0x3F800000 at c7; `done_o` = 1 at c7; `busy_o` = 0 at c8.
- Backpressure:
  - Stimulus: issue at c0 and c1; `ready_out_i` = 0.
  - Response: `stall_o` = 1 from c2. Both results buffered in order: 0x40000000 flags 2'b10, then 0x00000001 flags 2'b01. Head holds stable until ready is raised.
- Credit release:
  - Stimulus: `occ` = 2, `inflight` = 0; one pop at cN.
  - Response: `stall_o` = 0 at cN+1. An issue at cN+1 is accepted with `err_o` = 0.
- Illegal issue:
  - Stimulus: `issue_i` while `stall_o` = 1.
  - Response: `err_o` = 1 next cycle; `inflight` unchanged; buffer drains; `stall_o` stays 1 until `rst`.
- Spurious token:
  - Stimulus: `pipe_valid_i` with `inflight` = 0, result 0xDEADBEEF.
  - Response: `err_o` = 1 next cycle; `occ` stays 0; `valid_out_o` never asserts.
- Reset mid-operation:
  - Stimulus: assert `rst` with `occ` = 1 and `inflight` = 1.
  - Response: all outputs 0 immediately. After release, a late `pipe_valid_i` sets `err_o`.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU add/sub result side.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam int FLAG_OVF  = 1;
    localparam int FLAG_UDF  = 0;
    localparam int DEFAULT_W = 32;

endpackage

// File: rtl/result_fifo.sv
// Register-array FIFO holding {flags, result} entries; head is read combinationally.
module result_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                wdata,
    output logic [DW-1:0]                rdata,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // The upstream credit scheme guarantees push never sees a full buffer.
            if (push && !pop) begin
                occ <= occ + CW'(1);
            end else if (pop && !push) begin
                occ <= occ - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fpu_result_collector.sv
// Tail of the add/sub pipeline: buffers results, hands them to the consumer and
// throttles the input side with credits since the pipeline itself cannot stall.
module fpu_result_collector
    import fpu_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_i,
    input  logic         pipe_valid_i,
    input  logic [W-1:0] pipe_result_i,
    input  logic [1:0]   pipe_flags_i,
    input  logic         ready_out_i,
    output logic         valid_out_o,
    output logic [W-1:0] result_o,
    output logic [1:0]   flags_o,
    output logic         stall_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int CW = $clog2(DEPTH+1);

    state_t        state;
    logic [CW-1:0] occ;
    logic [CW-1:0] inflight;
    logic [CW:0]   credit_used;
    logic          issue_acc;
    logic          push;
    logic          pop;
    logic          violation;
    logic [W+1:0]  wdata;
    logic [W+1:0]  rdata;

    assign credit_used = {1'b0, occ} + {1'b0, inflight};
    assign stall_o     = (credit_used >= (CW+1)'(DEPTH)) | (state == ERROR);

    assign issue_acc = issue_i & ~stall_o;
    assign push      = pipe_valid_i & (inflight != '0) & (state != ERROR);
    assign pop       = valid_out_o & ready_out_i;
    assign violation = (issue_i & stall_o) | (pipe_valid_i & (inflight == '0));

    assign wdata = {pipe_flags_i[FLAG_OVF], pipe_flags_i[FLAG_UDF], pipe_result_i};

    result_fifo #(
        .DW    (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .occ   (occ)
    );

    assign valid_out_o = (occ != '0);
    assign result_o    = rdata[W-1:0];
    assign flags_o     = rdata[W+1:W];
    assign busy_o      = (occ != '0) | (inflight != '0);
    assign done_o      = pop & (occ == CW'(1)) & (inflight == '0) & ~push;
    assign err_o       = (state == ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (issue_acc && !push) begin
            inflight <= inflight + CW'(1);
        end else if (push && !issue_acc) begin
            inflight <= inflight - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (violation) begin
                        state <= ERROR;
                    end else if (issue_acc) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (violation) begin
                        state <= ERROR;
                    end else if (done_o && !issue_acc) begin
                        state <= IDLE;
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector (DEPTH=2): handshake, credits, errors, reset.
module tb_fpu_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_i;
    logic        pipe_valid_i;
    logic [31:0] pipe_result_i;
    logic [1:0]  pipe_flags_i;
    logic        ready_out_i;
    logic        valid_out_o;
    logic [31:0] result_o;
    logic [1:0]  flags_o;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int tests  = 0;
    int failed = 0;

    fpu_result_collector #(.W(32), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_i       (issue_i),
        .pipe_valid_i  (pipe_valid_i),
        .pipe_result_i (pipe_result_i),
        .pipe_flags_i  (pipe_flags_i),
        .ready_out_i   (ready_out_i),
        .valid_out_o   (valid_out_o),
        .result_o      (result_o),
        .flags_o       (flags_o),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        issue_i       = 1'b0;
        pipe_valid_i  = 1'b0;
        pipe_result_i = '0;
        pipe_flags_i  = '0;
        ready_out_i   = 1'b0;
        #2;
        chk("rst_valid", valid_out_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_flags", flags_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // single op: issue c0, token c6, handed off c7
        next();
        issue_i = 1'b1;
        #1;
        chk("t1_c0_stall", stall_o, 0);
        chk("t1_c0_busy", busy_o, 0);
        next();
        issue_i = 1'b0;
        #1;
        chk("t1_c1_busy", busy_o, 1);
        chk("t1_c1_stall", stall_o, 0);
        repeat (5) next();
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'h3F80_0000;
        pipe_flags_i  = 2'b00;
        ready_out_i   = 1'b1;
        #1;
        chk("t1_c6_nobypass", valid_out_o, 0);
        next();
        pipe_valid_i = 1'b0;
        #1;
        chk("t1_c7_valid", valid_out_o, 1);
        chk("t1_c7_result", result_o, 32'h3F80_0000);
        chk("t1_c7_flags", flags_o, 2'b00);
        chk("t1_c7_done", done_o, 1);
        next();
        ready_out_i = 1'b0;
        #1;
        chk("t1_c8_busy", busy_o, 0);
        chk("t1_c8_done", done_o, 0);
        chk("t1_c8_valid", valid_out_o, 0);

        // backpressure and credit release
        next();
        issue_i = 1'b1;
        next();
        #1;
        chk("t2_c1_stall", stall_o, 0);
        next();
        issue_i = 1'b0;
        #1;
        chk("t2_c2_stall", stall_o, 1);
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'h4000_0000;
        pipe_flags_i  = 2'b10;
        next();
        pipe_result_i = 32'h0000_0001;
        pipe_flags_i  = 2'b01;
        #1;
        chk("t2_c3_valid", valid_out_o, 1);
        chk("t2_c3_result", result_o, 32'h4000_0000);
        next();
        pipe_valid_i = 1'b0;
        #1;
        chk("t2_c4_result", result_o, 32'h4000_0000);
        chk("t2_c4_flags", flags_o, 2'b10);
        chk("t2_c4_stall", stall_o, 1);
        repeat (3) next();
        #1;
        chk("t2_hold_result", result_o, 32'h4000_0000);
        chk("t2_hold_flags", flags_o, 2'b10);
        chk("t2_hold_valid", valid_out_o, 1);
        ready_out_i = 1'b1;
        #1;
        chk("t2_pop1_done", done_o, 0);
        next();
        ready_out_i = 1'b0;
        #1;
        chk("t2_release_stall", stall_o, 0);
        chk("t2_second_result", result_o, 32'h0000_0001);
        chk("t2_second_flags", flags_o, 2'b01);
        issue_i = 1'b1;
        next();
        issue_i = 1'b0;
        #1;
        chk("t2_reissue_err", err_o, 0);
        chk("t2_reissue_stall", stall_o, 1);
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'h1234_5678;
        pipe_flags_i  = 2'b00;
        next();
        pipe_valid_i = 1'b0;
        ready_out_i  = 1'b1;
        #1;
        chk("t2_pop2_result", result_o, 32'h0000_0001);
        chk("t2_pop2_done", done_o, 0);
        next();
        #1;
        chk("t2_pop3_result", result_o, 32'h1234_5678);
        chk("t2_pop3_done", done_o, 1);
        next();
        ready_out_i = 1'b0;
        #1;
        chk("t2_end_busy", busy_o, 0);
        chk("t2_end_valid", valid_out_o, 0);

        // illegal issue while stalled
        do_reset();
        next();
        issue_i = 1'b1;
        next();
        next();
        issue_i       = 1'b0;
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'hAAAA_0001;
        pipe_flags_i  = 2'b00;
        #1;
        chk("t3_c2_stall", stall_o, 1);
        next();
        pipe_valid_i = 1'b0;
        issue_i      = 1'b1;
        #1;
        chk("t3_c3_err", err_o, 0);
        next();
        issue_i = 1'b0;
        #1;
        chk("t3_c4_err", err_o, 1);
        chk("t3_c4_inflight", dut.inflight, 1);
        chk("t3_c4_result", result_o, 32'hAAAA_0001);
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'hBBBB_0002;
        next();
        pipe_valid_i = 1'b0;
        ready_out_i  = 1'b1;
        #1;
        chk("t3_push_ignored_occ", dut.occ, 1);
        chk("t3_drain_result", result_o, 32'hAAAA_0001);
        next();
        ready_out_i = 1'b0;
        #1;
        chk("t3_drained_valid", valid_out_o, 0);
        chk("t3_drained_stall", stall_o, 1);
        repeat (3) next();
        #1;
        chk("t3_sticky_err", err_o, 1);
        chk("t3_sticky_stall", stall_o, 1);

        // spurious token
        do_reset();
        chk("t4_reset_err", err_o, 0);
        next();
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'hDEAD_BEEF;
        #1;
        chk("t4_c0_err", err_o, 0);
        next();
        pipe_valid_i = 1'b0;
        #1;
        chk("t4_c1_err", err_o, 1);
        chk("t4_c1_valid", valid_out_o, 0);
        chk("t4_c1_occ", dut.occ, 0);
        repeat (3) next();
        #1;
        chk("t4_later_valid", valid_out_o, 0);

        // reset mid-operation
        do_reset();
        next();
        issue_i = 1'b1;
        next();
        next();
        issue_i       = 1'b0;
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'h0000_0055;
        pipe_flags_i  = 2'b11;
        next();
        pipe_valid_i = 1'b0;
        #1;
        chk("t5_pre_occ", dut.occ, 1);
        chk("t5_pre_inflight", dut.inflight, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", valid_out_o, 0);
        chk("t5_rst_result", result_o, 0);
        chk("t5_rst_flags", flags_o, 0);
        chk("t5_rst_stall", stall_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_done", done_o, 0);
        chk("t5_rst_err", err_o, 0);
        @(negedge clk);
        rst = 1'b0;
        next();
        pipe_valid_i  = 1'b1;
        pipe_result_i = 32'h0000_0066;
        #1;
        chk("t5_late_err_before", err_o, 0);
        next();
        pipe_valid_i = 1'b0;
        #1;
        chk("t5_late_err_after", err_o, 1);
        chk("t5_late_valid", valid_out_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
